usb_receiver: RTL and testbench

High-speed USB line receiver: samples the differential pair one line bit per clock, decodes NRZI back to a serial bitstream, optionally removes stuffed bits, detects SE0 end-of-packet and illegal line states, and assembles LSB-first bytes. Sits at the far end of the link from the NRZI transmitter; its `d_plus`/`d_minus`/`in_data_valid` inputs connect directly to that transmitter's `d_plus`/`d_minus`/`out_data_valid`.

---
 rtl/usb_receiver.sv | 129 ++++++++++++
 tb/tb_usb_receiver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_receiver.sv
// High-speed USB line receiver: NRZI decode, optional bit unstuffing, SE0 EOP and line error detection, LSB-first byte assembly.
// Optional feature macro: USB_RX_UNSTUFF_EN enables stuffed-bit removal and stuff_err reporting.
module usb_receiver (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus,
    input  logic       d_minus,
    input  logic       in_data_valid,
    output logic       serial_out,
    output logic       out_data_valid,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       eop,
    output logic       stuff_err,
    output logic       line_err
);

    typedef enum logic [1:0] {IDLE, RX, SE0_WAIT, ERR} state_t;

    // Line level is tracked as the D+ value of a J/K sample, so J = 1
    localparam logic LVL_J = 1'b1;

    state_t     state;
    logic       prev;
    logic [2:0] bit_cnt;

    logic line_jk;
    logic line_se0;
    logic dec_bit;
    logic stuff_drop;
    logic stuff_viol;

    assign line_jk  = d_plus ^ d_minus;
    assign line_se0 = ~d_plus & ~d_minus;
    assign dec_bit  = ~(d_plus ^ prev);

`ifdef USB_RX_UNSTUFF_EN
    logic [2:0] ones_cnt;

    assign stuff_drop = (ones_cnt == 3'd6) && !dec_bit;
    assign stuff_viol = (ones_cnt == 3'd6) && dec_bit;

    // Run length of decoded ones; anything other than a J/K sample in IDLE/RX ends the run
    always_ff @(posedge clk) begin
        if (!rst || !in_data_valid) begin
            ones_cnt <= 3'd0;
        end else if ((state == IDLE || state == RX) && line_jk && !stuff_viol) begin
            ones_cnt <= dec_bit ? ones_cnt + 3'd1 : 3'd0;
        end else begin
            ones_cnt <= 3'd0;
        end
    end
`else
    assign stuff_drop = 1'b0;
    assign stuff_viol = 1'b0;
`endif

    // Receive FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            prev           <= LVL_J;
            bit_cnt        <= 3'd0;
            serial_out     <= 1'b0;
            out_data_valid <= 1'b0;
            data_byte      <= 8'h00;
            byte_valid     <= 1'b0;
            eop            <= 1'b0;
            stuff_err      <= 1'b0;
            line_err       <= 1'b0;
        end else begin
            out_data_valid <= 1'b0;
            byte_valid     <= 1'b0;
            eop            <= 1'b0;
            stuff_err      <= 1'b0;
            line_err       <= 1'b0;

            if (!in_data_valid) begin
                state   <= IDLE;
                prev    <= LVL_J;
                bit_cnt <= 3'd0;
            end else begin
                case (state)
                    IDLE, RX: begin
                        if (line_jk) begin
                            prev  <= d_plus;
                            state <= RX;
                            if (stuff_viol) begin
                                stuff_err <= 1'b1;
                                state     <= ERR;
                                bit_cnt   <= 3'd0;
                            end else if (!stuff_drop) begin
                                serial_out         <= dec_bit;
                                out_data_valid     <= 1'b1;
                                data_byte[bit_cnt] <= dec_bit;
                                byte_valid         <= (bit_cnt == 3'd7);
                                bit_cnt            <= bit_cnt + 3'd1;
                            end
                        end else if (line_se0) begin
                            state <= SE0_WAIT;
                        end else begin
                            line_err <= 1'b1;
                            state    <= ERR;
                            bit_cnt  <= 3'd0;
                        end
                    end
                    SE0_WAIT: begin
                        bit_cnt <= 3'd0;
                        if (line_se0) begin
                            eop   <= 1'b1;
                            prev  <= LVL_J;
                            state <= IDLE;
                        end else begin
                            line_err <= 1'b1;
                            state    <= ERR;
                        end
                    end
                    ERR: begin
                        bit_cnt <= 3'd0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_receiver.sv
// Scoreboard bench for usb_receiver: every driven cycle pushes its expected outputs, checked one edge later.
module tb_usb_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_plus;
    logic       d_minus;
    logic       in_data_valid;
    logic       serial_out;
    logic       out_data_valid;
    logic [7:0] data_byte;
    logic       byte_valid;
    logic       eop;
    logic       stuff_err;
    logic       line_err;

    localparam logic [1:0] LJ = 2'b10;
    localparam logic [1:0] LK = 2'b01;
    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b11;

    typedef struct packed {
        logic       ov;
        logic       sb;
        logic       bv;
        logic [7:0] byt;
        logic       eop;
        logic       serr;
        logic       lerr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    usb_receiver dut (
        .clk            (clk),
        .rst            (rst),
        .d_plus         (d_plus),
        .d_minus        (d_minus),
        .in_data_valid  (in_data_valid),
        .serial_out     (serial_out),
        .out_data_valid (out_data_valid),
        .data_byte      (data_byte),
        .byte_valid     (byte_valid),
        .eop            (eop),
        .stuff_err      (stuff_err),
        .line_err       (line_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t ex(input logic ov, input logic sb, input logic bv, input logic [7:0] byt,
                                input logic e, input logic se, input logic le);
        exp_t r;
        r.ov = ov; r.sb = sb; r.bv = bv; r.byt = byt; r.eop = e; r.serr = se; r.lerr = le;
        return r;
    endfunction

    // Drive one line sample at the falling edge and queue what must appear after the next rising edge
    task automatic step(input logic [1:0] s, input logic v, input exp_t e);
        @(negedge clk);
        d_plus        = s[1];
        d_minus       = s[0];
        in_data_valid = v;
        sb_q.push_back(e);
    endtask

    task automatic bitstep(input logic [1:0] s, input logic b);
        step(s, 1'b1, ex(1'b1, b, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic bytestep(input logic [1:0] s, input logic b, input logic [7:0] byt);
        step(s, 1'b1, ex(1'b1, b, 1'b1, byt, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic quiet(input logic [1:0] s, input logic v);
        step(s, v, ex(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic idle();
        quiet(2'($urandom), 1'b0);
    endtask

    // J,K,K,J,K,K,J,J decodes (against J) to 1,0,1,0,0,1,0,1 = 8'hA5
    task automatic send_a5();
        bitstep(LJ, 1'b1);
        bitstep(LK, 1'b0);
        bitstep(LK, 1'b1);
        bitstep(LJ, 1'b0);
        bitstep(LK, 1'b0);
        bitstep(LK, 1'b1);
        bitstep(LJ, 1'b0);
        bytestep(LJ, 1'b1, 8'hA5);
    endtask

    // Monitor: compare one expected record per cycle, shortly after the rising edge
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("out_data_valid", 8'(out_data_valid), 8'(mon_e.ov));
            if (mon_e.ov) check("serial_out", 8'(serial_out), 8'(mon_e.sb));
            check("byte_valid", 8'(byte_valid), 8'(mon_e.bv));
            if (mon_e.bv) check("data_byte", data_byte, mon_e.byt);
            check("eop", 8'(eop), 8'(mon_e.eop));
            check("stuff_err", 8'(stuff_err), 8'(mon_e.serr));
            check("line_err", 8'(line_err), 8'(mon_e.lerr));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b0;
        d_plus        = 1'($urandom);
        d_minus       = 1'($urandom);
        in_data_valid = 1'($urandom);
        repeat (2) begin
            @(negedge clk);
            d_plus        = 1'($urandom);
            d_minus       = 1'($urandom);
            in_data_valid = 1'($urandom);
        end
        @(negedge clk);
        check("rst_serial_out", 8'(serial_out), 8'h00);
        check("rst_out_data_valid", 8'(out_data_valid), 8'h00);
        check("rst_data_byte", data_byte, 8'h00);
        check("rst_byte_valid", 8'(byte_valid), 8'h00);
        check("rst_eop", 8'(eop), 8'h00);
        check("rst_stuff_err", 8'(stuff_err), 8'h00);
        check("rst_line_err", 8'(line_err), 8'h00);
        rst           = 1'b1;
        in_data_valid = 1'b0;

        // First byte after reset decodes against J
        send_a5();
        idle();

        // EOP: partial byte discarded, next packet starts fresh against J
        bitstep(LJ, 1'b1);
        bitstep(LK, 1'b0);
        bitstep(LJ, 1'b0);
        quiet(S0, 1'b1);
        step(S0, 1'b1, ex(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        send_a5();
        idle();

        // Seven J samples then K
        for (int i = 0; i < 6; i++) bitstep(LJ, 1'b1);
`ifdef USB_RX_UNSTUFF_EN
        step(LJ, 1'b1, ex(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
        quiet(LK, 1'b1);
`else
        bitstep(LJ, 1'b1);
        bytestep(LK, 1'b0, 8'h7F);
`endif
        idle();

        // Six J samples then K (the stuffed zero), then J, J
        for (int i = 0; i < 6; i++) bitstep(LJ, 1'b1);
`ifdef USB_RX_UNSTUFF_EN
        quiet(LK, 1'b1);
        bitstep(LJ, 1'b0);
        bytestep(LJ, 1'b1, 8'hBF);
`else
        bitstep(LK, 1'b0);
        bytestep(LJ, 1'b0, 8'h3F);
        bitstep(LJ, 1'b1);
`endif
        idle();

        // SE1 during RX, then the line is ignored until idle
        bitstep(LJ, 1'b1);
        bitstep(LK, 1'b0);
        step(S1, 1'b1, ex(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        quiet(LJ, 1'b1);
        quiet(LK, 1'b1);
        quiet(S0, 1'b1);
        quiet(S0, 1'b1);
        idle();

        // Lone SE0 followed by J
        bitstep(LJ, 1'b1);
        quiet(S0, 1'b1);
        step(LJ, 1'b1, ex(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        quiet(LK, 1'b1);
        idle();

        // Link drop after five bits, then a complete byte from bit 0
        bitstep(LJ, 1'b1);
        bitstep(LK, 1'b0);
        bitstep(LJ, 1'b0);
        bitstep(LJ, 1'b1);
        bitstep(LK, 1'b0);
        idle();
        idle();
        send_a5();
        idle();

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 8'(sb_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
